// File: rtl/alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_loader
// Brief    : Input stage for the 3-bit ALU. Synchronises and debounces the
//            load/clear buttons and sequences operand entry (a, b, op code)
//            from the switches into registered ALU inputs.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_loader #(
  parameter int DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sw,
  input  logic       btn_load,
  input  logic       btn_clear,
  output logic [2:0] a,
  output logic [2:0] b,
  output logic [1:0] sw_select,
  output logic       operands_valid,
  output logic [1:0] stage
);

  // Counter only has to reach DB_CYCLES-1, so clog2 bits suffice and it never wraps
  localparam int C_CNT_W = ($clog2(DB_CYCLES) < 1) ? 1 : $clog2(DB_CYCLES);
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(DB_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);

  // Index 0 is the load button, index 1 the clear button
  localparam int C_BTN_LOAD  = 0;
  localparam int C_BTN_CLEAR = 1;

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_OP   = 2'b10,
    S_DONE = 2'b11
  } state_t;

  logic [1:0] w_btn_raw;
  logic [1:0] w_press;

  assign w_btn_raw = {btn_clear, btn_load};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic               r_stable_d;
    logic               r_press;
    logic [C_CNT_W-1:0] r_cnt;

    // Two-flop synchroniser for the raw asynchronous button
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        r_sync1 <= w_btn_raw[gi];
        r_sync2 <= r_sync1;
      end
    end

    // Debounce: a new level is accepted only after DB_CYCLES consecutive cycles
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_stable <= 1'b0;
        r_cnt    <= '0;
      end else if (r_sync2 == r_stable) begin
        r_cnt    <= '0;
      end else if (r_cnt == C_CNT_MAX) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt    <= r_cnt + C_CNT_ONE;
      end
    end

    // One-cycle press pulse the cycle after the stable level rises; falls are ignored
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_stable_d <= 1'b0;
        r_press    <= 1'b0;
      end else begin
        r_stable_d <= r_stable;
        r_press    <= r_stable & ~r_stable_d;
      end
    end

    assign w_press[gi] = r_press;
  end : g_btn

  state_t     r_state;
  logic [2:0] r_a;
  logic [2:0] r_b;
  logic [1:0] r_sel;
  logic       r_valid;

  // Entry sequencer: clear has priority over a coincident load press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_A;
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else if (w_press[C_BTN_CLEAR]) begin
      r_state <= S_A;
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else if (w_press[C_BTN_LOAD]) begin
      case (r_state)
        S_A: begin
          r_a     <= sw;
          r_state <= S_B;
        end
        S_B: begin
          r_b     <= sw;
          r_state <= S_OP;
        end
        S_OP: begin
          r_sel   <= sw[1:0];
          r_valid <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          // Start a new set: b and the op code stay until overwritten
          r_a     <= sw;
          r_valid <= 1'b0;
          r_state <= S_B;
        end
        default: r_state <= S_A;
      endcase
    end
  end

  assign a              = r_a;
  assign b              = r_b;
  assign sw_select      = r_sel;
  assign operands_valid = r_valid;
  assign stage          = r_state;

endmodule : alu_operand_loader
`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_loader
// Brief    : Directed self-checking bench for alu_operand_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_loader;

  localparam int C_DB  = 16;
  localparam int C_LAT = C_DB + 4;

  logic       clk;
  logic       clk_run;
  logic       rst_n;
  logic [2:0] sw;
  logic       btn_load;
  logic       btn_clear;
  logic [2:0] a;
  logic [2:0] b;
  logic [1:0] sw_select;
  logic       operands_valid;
  logic [1:0] stage;

  int n_checks;
  int n_errors;

  alu_operand_loader #(.DB_CYCLES(C_DB)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sw             (sw),
    .btn_load       (btn_load),
    .btn_clear      (btn_clear),
    .a              (a),
    .b              (b),
    .sw_select      (sw_select),
    .operands_valid (operands_valid),
    .stage          (stage)
  );

  // Gated clock so it can be stopped (low) for the asynchronous reset test
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] ea, input logic [2:0] eb,
                           input logic [1:0] esel, input logic ev, input logic [1:0] est);
    check({tag, ".a"},     a,              ea);
    check({tag, ".b"},     b,              eb);
    check({tag, ".sel"},   sw_select,      esel);
    check({tag, ".valid"}, operands_valid, ev);
    check({tag, ".stage"}, stage,          est);
  endtask

  // Raise the buttons at a negedge, verify stage is unchanged one edge early and
  // updated exactly C_LAT edges after the rise, then release and let it settle.
  task automatic press(input string tag, input logic ld, input logic cl, input logic [2:0] swv,
                       input logic [1:0] st_before, input logic [1:0] st_after);
    @(negedge clk);
    sw        = swv;
    btn_load  = ld;
    btn_clear = cl;
    repeat (C_LAT - 1) @(posedge clk);
    #1 check({tag, ".early"}, stage, st_before);
    @(posedge clk);
    #1 check({tag, ".edge"}, stage, st_after);
    @(negedge clk);
    btn_load  = 1'b0;
    btn_clear = 1'b0;
    repeat (C_LAT + 4) @(posedge clk);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    clk_run   = 1'b1;
    rst_n     = 1'b0;
    sw        = 3'd0;
    btn_load  = 1'b0;
    btn_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all("reset", 3'd0, 3'd0, 2'd0, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Full entry sequence
    press("ld_a", 1'b1, 1'b0, 3'b101, 2'd0, 2'd1);
    check_all("after_a", 3'd5, 3'd0, 2'd0, 1'b0, 2'd1);
    press("ld_b", 1'b1, 1'b0, 3'b011, 2'd1, 2'd2);
    check_all("after_b", 3'd5, 3'd3, 2'd0, 1'b0, 2'd2);
    press("ld_op", 1'b1, 1'b0, 3'b110, 2'd2, 2'd3);
    check_all("full", 3'd5, 3'd3, 2'b10, 1'b1, 2'd3);

    // Re-entry from S_DONE keeps b and the op code
    press("reentry", 1'b1, 1'b0, 3'b111, 2'd3, 2'd1);
    check_all("reentry", 3'd7, 3'd3, 2'b10, 1'b0, 2'd1);

    // Clear from S_B
    press("clr", 1'b0, 1'b1, 3'b010, 2'd1, 2'd0);
    check_all("clr", 3'd0, 3'd0, 2'd0, 1'b0, 2'd0);

    // Bounce rejection: 3-cycle pulses and gaps never debounce
    @(negedge clk);
    sw = 3'b001;
    for (int i = 0; i < 20; i++) begin
      btn_load = (i % 2 == 0);
      repeat (3) @(negedge clk);
    end
    check("bounce.stage", stage, 2'd0);
    btn_load = 1'b1;
    repeat (C_LAT - 1) @(posedge clk);
    #1 check("bounce_hold.early", stage, 2'd0);
    @(posedge clk);
    #1 check("bounce_hold.edge", stage, 2'd1);
    check("bounce_hold.a", a, 3'd1);

    // Long hold: exactly one transition
    sw = 3'b100;
    repeat (300) @(posedge clk);
    #1 check("hold.stage", stage, 2'd1);
    check("hold.b", b, 3'd0);
    @(negedge clk);
    btn_load = 1'b0;
    repeat (C_LAT + 4) @(posedge clk);
    #1 check("hold_rel.stage", stage, 2'd1);

    // Clear priority over a simultaneous load in S_OP
    press("clr2", 1'b0, 1'b1, 3'b000, 2'd1, 2'd0);
    press("ld_a2", 1'b1, 1'b0, 3'd2, 2'd0, 2'd1);
    press("ld_b4", 1'b1, 1'b0, 3'd4, 2'd1, 2'd2);
    check_all("in_op", 3'd2, 3'd4, 2'd0, 1'b0, 2'd2);
    press("both", 1'b1, 1'b1, 3'b111, 2'd2, 2'd0);
    check_all("both", 3'd0, 3'd0, 2'd0, 1'b0, 2'd0);

    // Asynchronous reset mid-debounce with the clock stopped
    press("ld_a6", 1'b1, 1'b0, 3'd6, 2'd0, 2'd1);
    check("pre_rst.a", a, 3'd6);
    @(negedge clk);
    btn_load = 1'b1;
    sw       = 3'd5;
    repeat (8) @(negedge clk);
    clk_run  = 1'b0;
    btn_load = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_all("async_rst", 3'd0, 3'd0, 2'd0, 1'b0, 2'd0);
    #20 rst_n = 1'b1;
    #2 clk_run = 1'b1;
    repeat (C_LAT + 20) @(posedge clk);
    #1 check_all("post_rst", 3'd0, 3'd0, 2'd0, 1'b0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_alu_operand_loader
`default_nettype wire
